// File: rtl/spibus_bridge_if.sv
// spibus_bridge_if
// Cartridge bus connection between the SPI bridge (master) and cart_iface (slave).
//   cart_a    : bus address, ADDR_W bits
//   cart_dout : write data towards the bus
//   cart_din  : read data from the bus
//   cart_rd   : one-cycle read strobe
//   cart_wr   : one-cycle write strobe
//   cart_busy : bus access in progress
interface spibus_bridge_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] cart_a;
  logic [7:0]        cart_dout;
  logic [7:0]        cart_din;
  logic              cart_rd;
  logic              cart_wr;
  logic              cart_busy;

  modport master (
    output cart_a, cart_dout, cart_rd, cart_wr,
    input  cart_din, cart_busy
  );

  modport slave (
    input  cart_a, cart_dout, cart_rd, cart_wr,
    output cart_din, cart_busy
  );
endinterface

// File: rtl/spibus_bridge.sv
// spibus_bridge
// SPI slave (mode 0, MSB first) that turns SPI frames into single or burst
// byte reads/writes on the cartridge bus.
// Frame: command byte (bit7 = write, bit6 = auto-increment), ADDR_W/8 address
// bytes MSB first, then data bytes (write) or dummy + streamed read bytes (read).
// Ports:
//   clk, rst     : system clock, asynchronous active-low reset
//   spi_sck      : SPI clock (asynchronous, idles low)
//   spi_mosi     : serial data in
//   spi_cs       : chip select, selected when equal to CS_ACTIVE
//   spi_miso     : serial data out
//   cart         : cartridge bus (master side)
//   err_overrun  : sticky overrun flag, cleared at each frame start
module spibus_bridge #(
  parameter int ADDR_W    = 16,
  parameter bit CS_ACTIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_mosi,
  input  logic             spi_cs,
  output logic             spi_miso,
  spibus_bridge_if.master  cart,
  output logic             err_overrun
);

  localparam int         ADDR_BYTES = ADDR_W / 8;
  localparam logic [2:0] LAST_ADDR  = 3'(ADDR_BYTES);
  localparam logic [2:0] DATA_PHASE = 3'(ADDR_BYTES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT1  = 2'd2;
  localparam logic [1:0] ST_WAITB  = 2'd3;

  logic [1:0]        sck_sync, mosi_sync, cs_sync;
  logic              sck_prev, sel_prev;
  logic [2:0]        bit_cnt, byte_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic              is_wr, inc;
  logic [ADDR_W-1:0] addr;
  logic              req_pending, req_wr;
  logic [7:0]        req_data;
  logic [1:0]        state;
  logic              cur_rd;
  logic [7:0]        pref;

  logic       sel, sck_rise, sck_fall, frame_start, byte_done;
  logic [7:0] rx_byte;
  logic       bus_free, read_outstanding;

  assign sel         = (cs_sync[1] == CS_ACTIVE);
  assign sck_rise    = sck_sync[1] & ~sck_prev;
  assign sck_fall    = ~sck_sync[1] & sck_prev;
  assign frame_start = sel & ~sel_prev;
  assign rx_byte     = {rx_shift, mosi_sync[1]};
  // Frame start wins over a byte completing in the same cycle.
  assign byte_done   = sel & ~frame_start & sck_rise & (bit_cnt == 3'd7);

  assign bus_free         = (state == ST_IDLE) & ~req_pending;
  // A read is outstanding from the moment it is requested until its data is captured.
  assign read_outstanding = (req_pending & ~req_wr) | ((state != ST_IDLE) & cur_rd);

  // The bus FSM and the SPI frame logic share one block because both touch
  // addr and req_pending; the SPI part comes second so its requests win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync       <= '0;
      mosi_sync      <= '0;
      cs_sync        <= {2{~CS_ACTIVE}};
      sck_prev       <= 1'b0;
      sel_prev       <= 1'b0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      spi_miso       <= 1'b0;
      is_wr          <= 1'b0;
      inc            <= 1'b0;
      addr           <= '0;
      req_pending    <= 1'b0;
      req_wr         <= 1'b0;
      req_data       <= '0;
      state          <= ST_IDLE;
      cur_rd         <= 1'b0;
      pref           <= '0;
      err_overrun    <= 1'b0;
      cart.cart_a    <= '0;
      cart.cart_dout <= '0;
      cart.cart_rd   <= 1'b0;
      cart.cart_wr   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[0], spi_cs};
      sck_prev  <= sck_sync[1];
      sel_prev  <= sel;

      cart.cart_rd <= 1'b0;
      cart.cart_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_pending) begin
            state          <= ST_STROBE;
            cart.cart_a    <= addr;
            cart.cart_dout <= req_data;
            cart.cart_rd   <= ~req_wr;
            cart.cart_wr   <= req_wr;
            cur_rd         <= ~req_wr;
            req_pending    <= 1'b0;
          end
        end
        ST_STROBE: begin
          state <= ST_WAIT1;
          if (inc) addr <= addr + ADDR_W'(1);
        end
        ST_WAIT1: state <= ST_WAITB;
        default: begin
          if (!cart.cart_busy) begin
            if (cur_rd) pref <= cart.cart_din;
            state <= ST_IDLE;
          end
        end
      endcase

      if (frame_start) begin
        bit_cnt     <= '0;
        byte_cnt    <= '0;
        err_overrun <= 1'b0;
        tx_shift    <= '0;
        spi_miso    <= 1'b0;
        req_pending <= 1'b0;
      end else if (!sel) begin
        // Abort: drop any partial byte and any request not yet on the bus.
        bit_cnt     <= '0;
        req_pending <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        // The fall right after the 8th rise keeps the freshly loaded bit 7 on MISO.
        if (sck_fall && bit_cnt != 3'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          spi_miso <= tx_shift[6];
        end
        if (byte_done) begin
          if (byte_cnt != DATA_PHASE) byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == 3'd0) begin
            is_wr <= rx_byte[7];
            inc   <= rx_byte[6];
          end else if (byte_cnt <= LAST_ADDR) begin
            addr <= (addr << 8) | ADDR_W'(rx_byte);
            if (byte_cnt == LAST_ADDR && !is_wr) begin
              // Prefetch the first read; the dummy byte shifts out zeros meanwhile.
              req_pending <= 1'b1;
              req_wr      <= 1'b0;
              tx_shift    <= '0;
              spi_miso    <= 1'b0;
            end
          end else if (is_wr) begin
            if (bus_free) begin
              req_pending <= 1'b1;
              req_wr      <= 1'b1;
              req_data    <= rx_byte;
            end else begin
              err_overrun <= 1'b1;
            end
          end else if (read_outstanding) begin
            tx_shift    <= 8'hFF;
            spi_miso    <= 1'b1;
            err_overrun <= 1'b1;
          end else begin
            tx_shift    <= pref;
            spi_miso    <= pref[7];
            req_pending <= 1'b1;
            req_wr      <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spibus_bridge.sv
// tb_spibus_bridge
// Drives SPI frames into a 16-bit and a 24-bit bridge, models the cart bus
// (cart_din = cart_a[7:0], busy for a programmable number of cycles after each
// strobe) and compares captured bus accesses and MISO bytes with expectations.
module tb_spibus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic cs16 = 1'b0;
  logic cs24 = 1'b0;
  logic miso16, miso24, err16, err24;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spibus_bridge_if #(.ADDR_W(16)) bus16 ();
  spibus_bridge_if #(.ADDR_W(24)) bus24 ();

  spibus_bridge #(.ADDR_W(16), .CS_ACTIVE(1'b1)) dut16 (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs16),
    .spi_miso(miso16), .cart(bus16), .err_overrun(err16)
  );

  spibus_bridge #(.ADDR_W(24), .CS_ACTIVE(1'b1)) dut24 (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs24),
    .spi_miso(miso24), .cart(bus24), .err_overrun(err24)
  );

  // Cart bus models
  int busy_len16 = 3;
  int busy_cnt16 = 0;
  int busy_cnt24 = 0;
  assign bus16.cart_din  = bus16.cart_a[7:0];
  assign bus16.cart_busy = (busy_cnt16 != 0);
  assign bus24.cart_din  = bus24.cart_a[7:0];
  assign bus24.cart_busy = (busy_cnt24 != 0);

  always @(posedge clk) begin
    if (bus16.cart_rd || bus16.cart_wr) busy_cnt16 <= busy_len16;
    else if (busy_cnt16 != 0)           busy_cnt16 <= busy_cnt16 - 1;
    if (bus24.cart_rd || bus24.cart_wr) busy_cnt24 <= 3;
    else if (busy_cnt24 != 0)           busy_cnt24 <= busy_cnt24 - 1;
  end

  // Bus access recorders
  logic [31:0] wr_a16[$], rd_a16[$], wr_a24[$], rd_a24[$];
  logic [7:0]  wr_d16[$], wr_d24[$];
  bit both_seen = 1'b0;

  always @(posedge clk) begin
    if (bus16.cart_wr) begin wr_a16.push_back(32'(bus16.cart_a)); wr_d16.push_back(bus16.cart_dout); end
    if (bus16.cart_rd) rd_a16.push_back(32'(bus16.cart_a));
    if (bus24.cart_wr) begin wr_a24.push_back(32'(bus24.cart_a)); wr_d24.push_back(bus24.cart_dout); end
    if (bus24.cart_rd) rd_a24.push_back(32'(bus24.cart_a));
    if ((bus16.cart_rd && bus16.cart_wr) || (bus24.cart_rd && bus24.cart_wr)) both_seen = 1'b1;
  end

  typedef struct packed {
    logic [0:7][7:0]  frame;
    logic [3:0]       nbytes;
    logic             use24;
    logic [2:0]       nexp;
    logic [2:0]       nrd;
    logic [0:3][31:0] exp_a;
    logic [0:3][7:0]  exp_d;
  } vec_t;

  vec_t vecs[4];

  function automatic vec_t mk(input logic [0:7][7:0] frame, input int n, input bit use24,
                              input int nexp, input int nrd,
                              input logic [0:3][31:0] exp_a, input logic [0:3][7:0] exp_d);
    vec_t v;
    v.frame  = frame;
    v.nbytes = 4'(n);
    v.use24  = use24;
    v.nexp   = 3'(nexp);
    v.nrd    = 3'(nrd);
    v.exp_a  = exp_a;
    v.exp_d  = exp_d;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_wr_a(input bit use24, input int i);
    if (use24) return (i < wr_a24.size()) ? wr_a24[i] : 32'hDEAD_BEEF;
    return (i < wr_a16.size()) ? wr_a16[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] q_wr_d(input bit use24, input int i);
    if (use24) return (i < wr_d24.size()) ? 32'(wr_d24[i]) : 32'hDEAD_BEEF;
    return (i < wr_d16.size()) ? 32'(wr_d16[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] q_rd_a(input bit use24, input int i);
    if (use24) return (i < rd_a24.size()) ? rd_a24[i] : 32'hDEAD_BEEF;
    return (i < rd_a16.size()) ? rd_a16[i] : 32'hDEAD_BEEF;
  endfunction

  // One SPI byte, sck = clk/8; MISO is sampled just before each rising edge.
  task automatic spi_byte(input logic [7:0] b, input bit use24, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      r[i] = use24 ? miso24 : miso16;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [0:7][7:0] frame, input int n, input bit use24,
                                output logic [0:7][7:0] rx);
    logic [7:0] r;
    wr_a16.delete(); wr_d16.delete(); rd_a16.delete();
    wr_a24.delete(); wr_d24.delete(); rd_a24.delete();
    rx = '0;
    @(negedge clk);
    if (use24) cs24 = 1'b1; else cs16 = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      spi_byte(frame[k], use24, r);
      rx[k] = r;
    end
    repeat (24) @(negedge clk);
    cs16 = 1'b0;
    cs24 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Reference model for 16-bit frames: expected accesses follow from plain address arithmetic.
  task automatic model_check(input logic [0:7][7:0] frame, input int n, input logic [0:7][7:0] rx);
    logic [15:0] a;
    logic [15:0] ea;
    int step;
    a    = {frame[1], frame[2]};
    step = frame[0][6] ? 1 : 0;
    if (frame[0][7]) begin
      check_output("rnd_wr_count", 32'(wr_a16.size()), 32'(n - 3));
      for (int i = 0; i < n - 3; i++) begin
        ea = a + 16'(i * step);
        check_output("rnd_wr_addr", q_wr_a(1'b0, i), 32'(ea));
        check_output("rnd_wr_data", q_wr_d(1'b0, i), 32'(frame[3 + i]));
      end
    end else begin
      check_output("rnd_rd_no_writes", 32'(wr_a16.size()), 32'd0);
      check_output("rnd_rd_count", 32'(rd_a16.size()), 32'(n - 2));
      for (int i = 0; i < n - 2; i++) begin
        ea = a + 16'(i * step);
        check_output("rnd_rd_addr", q_rd_a(1'b0, i), 32'(ea));
      end
      check_output("rnd_miso_dummy", 32'(rx[3]), 32'd0);
      for (int j = 0; j < n - 4; j++) begin
        ea = a + 16'(j * step);
        check_output("rnd_miso_data", 32'(rx[4 + j]), 32'(ea[7:0]));
      end
    end
  endtask

  initial begin
    logic [0:7][7:0] rx;
    logic [0:7][7:0] fr;
    int n, ab;

    vecs[0] = mk({8'hC0, 8'h80, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00}, 6, 1'b0, 3, 0,
                 {32'h8000, 32'h8001, 32'h8002, 32'h0}, {8'h01, 8'h02, 8'h03, 8'h00});
    vecs[1] = mk({8'h80, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00}, 5, 1'b0, 2, 0,
                 {32'h1234, 32'h1234, 32'h0, 32'h0}, {8'hAA, 8'hBB, 8'h00, 8'h00});
    vecs[2] = mk({8'h40, 8'h12, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 1'b0, 4, 5,
                 {32'h12FE, 32'h12FF, 32'h1300, 32'h0}, {8'h00, 8'hFE, 8'hFF, 8'h00});
    vecs[3] = mk({8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'h55, 8'h66, 8'h00, 8'h00}, 6, 1'b1, 2, 0,
                 {32'hFFFFFF, 32'h000000, 32'h0, 32'h0}, {8'h55, 8'h66, 8'h00, 8'h00});

    // Reset state
    repeat (4) @(negedge clk);
    check_output("rst_miso", 32'(miso16), 32'd0);
    check_output("rst_cart_a", 32'(bus16.cart_a), 32'd0);
    check_output("rst_cart_dout", 32'(bus16.cart_dout), 32'd0);
    check_output("rst_cart_rd", 32'(bus16.cart_rd), 32'd0);
    check_output("rst_cart_wr", 32'(bus16.cart_wr), 32'd0);
    check_output("rst_err", 32'(err16), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Directed table
    for (int v = 0; v < 4; v++) begin
      apply_stimulus(vecs[v].frame, int'(vecs[v].nbytes), vecs[v].use24, rx);
      ab = vecs[v].use24 ? 3 : 2;
      if (vecs[v].frame[0][7]) begin
        check_output("tbl_wr_count",
                     vecs[v].use24 ? 32'(wr_a24.size()) : 32'(wr_a16.size()), 32'(vecs[v].nexp));
        for (int i = 0; i < int'(vecs[v].nexp); i++) begin
          check_output("tbl_wr_addr", q_wr_a(vecs[v].use24, i), vecs[v].exp_a[i]);
          check_output("tbl_wr_data", q_wr_d(vecs[v].use24, i), 32'(vecs[v].exp_d[i]));
        end
      end else begin
        for (int i = 0; i < int'(vecs[v].nexp); i++)
          check_output("tbl_miso", 32'(rx[ab + 1 + i]), 32'(vecs[v].exp_d[i]));
        check_output("tbl_rd_count", 32'(rd_a16.size()), 32'(vecs[v].nrd));
        for (int i = 0; i < 3; i++)
          check_output("tbl_rd_addr", q_rd_a(vecs[v].use24, i), vecs[v].exp_a[i]);
      end
      check_output("tbl_err", 32'(vecs[v].use24 ? err24 : err16), 32'd0);
    end

    // Long bus busy during a write burst: second data byte is dropped
    busy_len16 = 200;
    fr = {8'h80, 8'h10, 8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00};
    apply_stimulus(fr, 5, 1'b0, rx);
    check_output("ovr_wr_count", 32'(wr_a16.size()), 32'd1);
    check_output("ovr_wr_addr", q_wr_a(1'b0, 0), 32'h1000);
    check_output("ovr_wr_data", q_wr_d(1'b0, 0), 32'hA1);
    check_output("ovr_err_set", 32'(err16), 32'd1);
    repeat (220) @(negedge clk);
    busy_len16 = 3;
    check_output("ovr_err_sticky", 32'(err16), 32'd1);
    cs16 = 1'b1;
    repeat (6) @(negedge clk);
    check_output("ovr_err_cleared", 32'(err16), 32'd0);
    cs16 = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized frames on the 16-bit bridge
    for (int t = 0; t < 8; t++) begin
      n = 4 + int'($urandom_range(0, 4));
      fr = '0;
      fr[0] = {1'($urandom), 1'($urandom), 6'($urandom)};
      for (int k = 1; k < 8; k++) fr[k] = 8'($urandom);
      apply_stimulus(fr, n, 1'b0, rx);
      model_check(fr, n, rx);
    end

    // Reset in the middle of a read burst
    wr_a16.delete(); wr_d16.delete(); rd_a16.delete();
    cs16 = 1'b1;
    repeat (6) @(negedge clk);
    fr = {8'h40, 8'h20, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 5; k++) begin
      logic [7:0] r;
      spi_byte(fr[k], 1'b0, r);
    end
    repeat (8) @(negedge clk);
    check_output("mid_cart_a", 32'(bus16.cart_a), 32'h20F2);
    check_output("mid_miso", 32'(miso16), 32'd1);
    rst = 1'b0;
    #1;
    check_output("arst_miso", 32'(miso16), 32'd0);
    check_output("arst_cart_a", 32'(bus16.cart_a), 32'd0);
    check_output("arst_cart_rd", 32'(bus16.cart_rd), 32'd0);
    check_output("arst_cart_wr", 32'(bus16.cart_wr), 32'd0);
    check_output("arst_err", 32'(err16), 32'd0);
    cs16 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    fr = {8'h80, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00};
    apply_stimulus(fr, 5, 1'b0, rx);
    model_check(fr, 5, rx);

    check_output("no_rd_wr_overlap", 32'(both_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spibus_bridge.md
# spibus_bridge

Parametrised SPI-slave-to-cartridge-bus bridge, the successor to `spicart`. It sits between the external SPI debug/loader link and `cart_iface`, and turns SPI frames into single or burst byte reads and writes on the cart bus. It adds three capabilities:
- a configurable address width;
- optional address auto-increment;
- streamed burst reads with one-byte prefetch, plus overrun detection.

## Interface
Parameters:
- `ADDR_W`, default 16: cart bus address width; a multiple of 8, in the range 8..32. `ADDR_BYTES = ADDR_W/8`.
- `CS_ACTIVE`, default 1: the level of `spi_cs` that selects the bridge.

Ports:
- `clk` in 1: system clock; all logic runs in this single domain.
- `rst` in 1: asynchronous, active-low reset.
- `spi_sck` in 1: SPI clock, asynchronous to `clk`; idles low (mode 0).
- `spi_mosi` in 1: serial data in, MSB first.
- `spi_cs` in 1: chip select; the bridge is selected when `spi_cs == CS_ACTIVE`.
- `spi_miso` out 1: serial data out, MSB first.
- `cart_a` out `ADDR_W`: bus address.
- `cart_dout` out 8: write data to the bus.
- `cart_din` in 8: read data from the bus.
- `cart_rd` out 1: one-cycle read strobe.
- `cart_wr` out 1: one-cycle write strobe.
- `cart_busy` in 1: bus access in progress.
- `err_overrun` out 1: sticky error flag; cleared at the start of each frame.

## Operation
**Input conditioning**
- `spi_sck`, `spi_mosi` and `spi_cs` each pass through a 2-FF synchroniser.
- Rise and fall events of `sck` are detected from the synchronised value.

**Framing**
- A frame starts when CS goes active and ends when CS goes inactive.
- The bit counter and byte counter reset at frame start.
- The bridge samples MOSI on each sck rise; a byte completes on the 8th rise.

**Frame format**
- Byte 0: command.
  - bit7 = 1 selects write, 0 selects read.
  - bit6 = 1 enables address auto-increment.
  - bits 5:0 are ignored.
- Bytes 1..`ADDR_BYTES`: start address, MSB first, loaded into `addr`.
- Write frame: every following byte becomes one bus write to `addr`. After the strobe is issued, `addr` increments if `inc` is set. The increment wraps modulo 2^`ADDR_W`.
- Read frame:
  - When the last address byte completes, the bridge issues a read of `addr` (prefetch).
  - The next byte is a dummy; MISO outputs 0x00 during it.
  - Each byte after the dummy shifts out the prefetched value.
  - The load into the TX shift register happens at the byte boundary, that is, the 8th sck rise of the preceding byte. That load triggers a read of the next address (incremented if `inc` is set, otherwise the same address).
- MISO changes on sck fall. Bit 7 of a newly loaded byte is driven immediately after the load.

**Bus state machine**
- States: IDLE, STROBE, WAIT1, WAITB.
- IDLE moves to STROBE when a request is pending.
- STROBE asserts `cart_rd` or `cart_wr` for exactly 1 cycle, with `cart_a` and `cart_dout` stable.
- WAIT1 is an unconditional 1-cycle state.
- WAITB holds while `cart_busy = 1`. On the first cycle with `cart_busy = 0`, it captures `cart_din` into the prefetch register (reads only) and returns to IDLE.
- `cart_a` and `cart_dout` hold their values from STROBE through the exit from WAITB.

**Overrun**
`err_overrun` is set in either case:
- a write byte completes while the bus FSM is not IDLE; the new byte is dropped;
- a TX load occurs while the read prefetch is still outstanding; 0xFF is shifted out instead.

**Frame abort**
- CS going inactive mid-byte discards the partial byte.
- An in-flight bus access still completes.
- No new requests are issued until the next frame.

**Reset values**
- `spi_miso` = 0, `cart_a` = 0, `cart_dout` = 0, `cart_rd` = 0, `cart_wr` = 0, `err_overrun` = 0.
- FSM in IDLE; counters at 0.

## Timing
- sck frequency must be at most `clk`/4.
- Sync latency: a byte-complete event occurs 3 `clk` cycles after the sck edge.
- The bus strobe follows byte-complete by 1 cycle, with no other request pending.
- Read prefetch must finish within 8 sck periods minus 6 `clk` cycles. Otherwise `err_overrun` is set.
- The bridge never asserts `cart_rd` and `cart_wr` together.
- It never issues a strobe while the FSM is outside IDLE.
- A frame-start in the same cycle as a byte-complete gives priority to frame-start.

## Test plan
The bench model: `cart_din = cart_a[7:0]`; `cart_busy` is high for 3 cycles starting the cycle after a strobe; sck = `clk`/8.
1. Write frame 0xC0,0x80,0x00,0x01,0x02,0x03 → writes of 0x01,0x02,0x03 to addresses 0x8000, 0x8001, 0x8002; exactly 3 `cart_wr` pulses.
2. Write frame 0x80,0x12,0x34,0xAA,0xBB (no increment) → two writes to 0x1234 with data 0xAA, then 0xBB.
3. Read frame 0x40,0x12,0xFE, dummy, then 3 bytes → MISO bytes 0x00, 0xFE, 0xFF, 0x00. Address wraps from 0xFFFF… is not exercised here; `cart_a` sequence is 0x12FE, 0x12FF, 0x1300.
4. `ADDR_W` = 24, write frame 0xC0,0xFF,0xFF,0xFF,0x55,0x66 → writes to 0xFFFFFF, then 0x000000 (wrap).
5. `cart_busy` held high for 200 cycles during a write burst → second data byte dropped; `err_overrun` = 1; `err_overrun` clears on the next CS assertion.
6. Assert `rst` low mid-read-burst → all outputs return to reset values immediately; the next frame operates normally.
